// File: rtl/rv_seq_ctrl_if.sv
// Instruction-memory fetch port for the RV32I multi-cycle sequencer.
// The sequencer is the master: it drives req/addr and receives ack/rdata.
interface rv_seq_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/rv_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the RV32I OP-IMM/OP subset.
// It owns the PC, the instruction register and the retired-instruction counter.
module rv_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    rv_seq_ctrl_if.master        imem,
    output logic [31:0]          ir,
    input  logic                 dec_wrt_en,
    output logic                 alu_en,
    output logic                 rf_we,
    output logic [31:0]          pc,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic [31:0]          instret
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } seq_state_t;

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  F7_ZERO    = 7'h00;
    localparam logic [6:0]  F7_ALT     = 7'h20;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    seq_state_t  state_r;
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic        illegal_r;
    logic [31:0] instret_r;
    logic        legal_s;

    // Supported-encoding check; funct7 only qualifies shifts (OP-IMM) and SUB/SRA (OP).
    function automatic logic is_legal(input logic [6:0] opcode,
                                      input logic [2:0] funct3,
                                      input logic [6:0] funct7);
        logic ok_v;
        ok_v = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                case (funct3)
                    3'b001:  ok_v = (funct7 == F7_ZERO);
                    3'b101:  ok_v = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    default: ok_v = 1'b1;
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_ZERO) begin
                    ok_v = 1'b1;
                end else if (funct7 == F7_ALT) begin
                    ok_v = (funct3 == 3'b000) || (funct3 == 3'b101);
                end else begin
                    ok_v = 1'b0;
                end
            end
            default: ok_v = 1'b0;
        endcase
        return ok_v;
    endfunction

    assign legal_s = is_legal(ir_r[6:0], ir_r[14:12], ir_r[31:25]);

    // Sequencer FSM plus PC, IR, trap flag and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            pc_r      <= RESET_PC;
            ir_r      <= NOP_INSN;
            illegal_r <= 1'b0;
            instret_r <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r <= run ? S_FETCH : S_IDLE;
                end
                S_FETCH: begin
                    if (imem.ack) begin
                        ir_r    <= imem.rdata;
                        state_r <= S_DECODE;
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    if (legal_s) begin
                        state_r <= S_EXECUTE;
                    end else begin
                        illegal_r <= 1'b1;
                        state_r   <= S_TRAP;
                    end
                end
                S_EXECUTE: begin
                    state_r <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    pc_r      <= pc_r + 32'd4;
                    instret_r <= instret_r + 32'd1;
                    state_r   <= run ? S_FETCH : S_IDLE;
                end
                S_TRAP: begin
                    state_r <= S_TRAP;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are pure decodes of the state register so they can never leak into other states.
    always_comb begin
        imem.req = (state_r == S_FETCH);
        alu_en   = (state_r == S_EXECUTE);
        if (state_r == S_WRITEBACK) begin
            rf_we = dec_wrt_en && (ir_r[11:7] != 5'd0);
        end else begin
            rf_we = 1'b0;
        end
    end

    assign imem.addr = pc_r;
    assign ir        = ir_r;
    assign pc        = pc_r;
    assign state     = state_r;
    assign illegal   = illegal_r;
    assign instret   = instret_r;

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// Directed self-checking bench for rv_seq_ctrl: fetch, wait states, x0 writes,
// legality table, traps, run drop, PC wrap and reset mid-fetch.
module tb_rv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        ack;
    logic [31:0] rdata;
    logic        dec_wrt_en;

    logic [31:0] ir, pc, instret;
    logic        alu_en, rf_we, illegal;
    logic [2:0]  state;

    logic [31:0] ir2, pc2, instret2;
    logic        alu_en2, rf_we2, illegal2;
    logic [2:0]  state2;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    rv_seq_ctrl_if bus ();
    rv_seq_ctrl_if bus2 ();

    assign bus.ack    = ack;
    assign bus.rdata  = rdata;
    assign bus2.ack   = ack;
    assign bus2.rdata = rdata;

    always #5 clk = ~clk;

    rv_seq_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .imem(bus.master), .ir(ir),
        .dec_wrt_en(dec_wrt_en), .alu_en(alu_en), .rf_we(rf_we), .pc(pc),
        .state(state), .illegal(illegal), .instret(instret)
    );

    rv_seq_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .run(run), .imem(bus2.master), .ir(ir2),
        .dec_wrt_en(dec_wrt_en), .alu_en(alu_en2), .rf_we(rf_we2), .pc(pc2),
        .state(state2), .illegal(illegal2), .instret(instret2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ack = 1'b0; run = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rdata = 32'd0; dec_wrt_en = 1'b0;
        do_reset();
        chk_cnt++; if (state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state); else pass_cnt++;
        chk_cnt++; if (pc !== 32'd0) $display("FAIL reset_pc got=%h exp=0", pc); else pass_cnt++;
        chk_cnt++; if (pc2 !== 32'hFFFF_FFFC) $display("FAIL reset_pc_param got=%h exp=fffffffc", pc2); else pass_cnt++;
        chk_cnt++; if (ir !== 32'h0000_0013) $display("FAIL reset_ir got=%h exp=00000013", ir); else pass_cnt++;
        chk_cnt++; if ({illegal, instret} !== 33'd0) $display("FAIL reset_flags illegal=%b instret=%0d exp=0/0", illegal, instret); else pass_cnt++;
        chk_cnt++; if ({bus.req, alu_en, rf_we} !== 3'b000) $display("FAIL reset_strobes got=%b exp=000", {bus.req, alu_en, rf_we}); else pass_cnt++;
    endtask

    task automatic test_fetch();
        run = 1'b1; dec_wrt_en = 1'b1;
        step();
        chk_cnt++; if (state !== 3'd1 || bus.req !== 1'b1 || bus.addr !== 32'd0) $display("FAIL t1_fetch state=%0d req=%b addr=%h exp=1/1/0", state, bus.req, bus.addr); else pass_cnt++;
        ack = 1'b1; rdata = 32'h0050_0093;
        step();
        ack = 1'b0;
        chk_cnt++; if (state !== 3'd2 || ir !== 32'h0050_0093) $display("FAIL t1_decode state=%0d ir=%h exp=2/00500093", state, ir); else pass_cnt++;
        step();
        chk_cnt++; if (state !== 3'd3 || alu_en !== 1'b1) $display("FAIL t1_execute state=%0d alu_en=%b exp=3/1", state, alu_en); else pass_cnt++;
        step();
        chk_cnt++; if (state !== 3'd4 || rf_we !== 1'b1 || alu_en !== 1'b0) $display("FAIL t1_wb state=%0d rf_we=%b alu_en=%b exp=4/1/0", state, rf_we, alu_en); else pass_cnt++;
        step();
        chk_cnt++; if (state !== 3'd1 || pc !== 32'd4 || instret !== 32'd1) $display("FAIL t1_retire state=%0d pc=%h instret=%0d exp=1/4/1", state, pc, instret); else pass_cnt++;
    endtask

    task automatic test_wait_states();
        int cyc;
        int req_ok;
        cyc = 0; req_ok = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.req === 1'b1 && bus.addr === 32'd4 && state === 3'd1) req_ok++;
            if (i == 3) begin ack = 1'b1; rdata = 32'h0070_0113; end
            step(); cyc++;
        end
        ack = 1'b0;
        chk_cnt++; if (req_ok !== 4) $display("FAIL t2_req_hold got=%0d exp=4 cycles", req_ok); else pass_cnt++;
        while (state !== 3'd1 && cyc < 20) begin
            step(); cyc++;
        end
        chk_cnt++; if (cyc !== 7) $display("FAIL t2_latency got=%0d exp=7", cyc); else pass_cnt++;
        chk_cnt++; if (pc !== 32'd8 || instret !== 32'd2) $display("FAIL t2_retire pc=%h instret=%0d exp=8/2", pc, instret); else pass_cnt++;
    endtask

    task automatic test_x0_dest();
        int alu_cnt;
        int we_cnt;
        int cyc;
        alu_cnt = 0; we_cnt = 0; cyc = 0;
        ack = 1'b1; rdata = 32'h0020_8033;
        step();
        ack = 1'b0;
        while (state !== 3'd1 && cyc < 10) begin
            if (alu_en === 1'b1) alu_cnt++;
            if (rf_we === 1'b1) we_cnt++;
            step(); cyc++;
        end
        chk_cnt++; if (alu_cnt !== 1) $display("FAIL t3_alu_pulses got=%0d exp=1", alu_cnt); else pass_cnt++;
        chk_cnt++; if (we_cnt !== 0) $display("FAIL t3_rf_we got=%0d exp=0", we_cnt); else pass_cnt++;
        chk_cnt++; if (instret !== 32'd3 || pc !== 32'd12) $display("FAIL t3_retire instret=%0d pc=%h exp=3/c", instret, pc); else pass_cnt++;
    endtask

    task automatic test_illegal();
        int req_cnt;
        req_cnt = 0;
        ack = 1'b1; rdata = 32'h0000_006F;
        step();
        ack = 1'b0;
        chk_cnt++; if (illegal !== 1'b0) $display("FAIL t4_early_illegal got=%b exp=0", illegal); else pass_cnt++;
        step();
        chk_cnt++; if (illegal !== 1'b1 || state !== 3'd5 || pc !== 32'd12) $display("FAIL t4_jal_trap illegal=%b state=%0d pc=%h exp=1/5/c", illegal, state, pc); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            ack = (i % 2 == 0); rdata = 32'h0050_0093;
            if (bus.req === 1'b1 || alu_en === 1'b1 || rf_we === 1'b1) req_cnt++;
            step();
        end
        ack = 1'b0;
        chk_cnt++; if (req_cnt !== 0) $display("FAIL t4_trap_strobes got=%0d exp=0", req_cnt); else pass_cnt++;
        chk_cnt++; if (state !== 3'd5 || pc !== 32'd12 || ir !== 32'h0000_006F || instret !== 32'd3) $display("FAIL t4_frozen state=%0d pc=%h ir=%h instret=%0d exp=5/c/6f/3", state, pc, ir, instret); else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cnt++; if (illegal !== 1'b0 || state !== 3'd0) $display("FAIL t6_trap_reset illegal=%b state=%0d exp=0/0", illegal, state); else pass_cnt++;
        step();
        ack = 1'b1; rdata = 32'h4000_1013;
        step();
        ack = 1'b0;
        step();
        chk_cnt++; if (illegal !== 1'b1 || state !== 3'd5 || pc !== 32'd0) $display("FAIL t4_slli_trap illegal=%b state=%0d pc=%h exp=1/5/0", illegal, state, pc); else pass_cnt++;
    endtask

    task automatic test_decode_table();
        logic [31:0] insn [11];
        logic        ok   [11];
        insn[0]  = 32'h0050_0093; ok[0]  = 1'b1;
        insn[1]  = 32'h4000_5013; ok[1]  = 1'b1;
        insn[2]  = 32'h0200_5013; ok[2]  = 1'b0;
        insn[3]  = 32'h0000_1013; ok[3]  = 1'b1;
        insn[4]  = 32'h4000_0033; ok[4]  = 1'b1;
        insn[5]  = 32'h4000_5033; ok[5]  = 1'b1;
        insn[6]  = 32'h4000_1033; ok[6]  = 1'b0;
        insn[7]  = 32'h0200_0033; ok[7]  = 1'b0;
        insn[8]  = 32'h0000_7033; ok[8]  = 1'b1;
        insn[9]  = 32'h4000_2013; ok[9]  = 1'b1;
        insn[10] = 32'h0000_0003; ok[10] = 1'b0;
        for (int k = 0; k < 11; k++) begin
            do_reset();
            run = 1'b1;
            step();
            ack = 1'b1; rdata = insn[k];
            step();
            ack = 1'b0;
            step();
            chk_cnt++;
            if (state !== (ok[k] ? 3'd3 : 3'd5) || illegal !== !ok[k])
                $display("FAIL legality insn=%h state=%0d illegal=%b exp_legal=%b", insn[k], state, illegal, ok[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_run_drop_wrap();
        do_reset();
        run = 1'b1;
        step();
        ack = 1'b1; rdata = 32'h0050_0093;
        step();
        ack = 1'b0;
        step();
        run = 1'b0;
        step();
        chk_cnt++; if (state !== 3'd4 || rf_we !== 1'b1) $display("FAIL t5_wb_after_drop state=%0d rf_we=%b exp=4/1", state, rf_we); else pass_cnt++;
        step();
        chk_cnt++; if (state !== 3'd0 || bus.req !== 1'b0 || instret !== 32'd1 || pc !== 32'd4) $display("FAIL t5_idle state=%0d req=%b instret=%0d pc=%h exp=0/0/1/4", state, bus.req, instret, pc); else pass_cnt++;
        chk_cnt++; if (pc2 !== 32'd0 || instret2 !== 32'd1) $display("FAIL t5_pc_wrap pc=%h instret=%0d exp=0/1", pc2, instret2); else pass_cnt++;
        step();
        chk_cnt++; if (state !== 3'd0) $display("FAIL t5_stay_idle got=%0d exp=0", state); else pass_cnt++;
    endtask

    task automatic test_reset_mid_fetch();
        run = 1'b1;
        step();
        chk_cnt++; if (state !== 3'd1 || bus.req !== 1'b1) $display("FAIL t6_run_to_req state=%0d req=%b exp=1/1", state, bus.req); else pass_cnt++;
        ack = 1'b1; rdata = 32'h0000_7033; rst = 1'b1;
        step();
        rst = 1'b0; ack = 1'b0;
        chk_cnt++; if (state !== 3'd0 || bus.req !== 1'b0 || ir !== 32'h0000_0013 || pc !== 32'd0 || instret !== 32'd0) $display("FAIL t6_mid_fetch state=%0d req=%b ir=%h pc=%h instret=%0d exp=0/0/13/0/0", state, bus.req, ir, pc, instret); else pass_cnt++;
        step();
        chk_cnt++; if (state !== 3'd1 || bus.req !== 1'b1) $display("FAIL t6_refetch state=%0d req=%b exp=1/1", state, bus.req); else pass_cnt++;
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_wait_states();
        test_x0_dest();
        test_illegal();
        test_decode_table();
        test_run_drop_wrap();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
